gf_div4: RTL

- Sequential divider over GF(2^4): computes quotient q = a · b⁻¹.
- Companion to the team's combinational GF(2^4) multiplier. It undoes a multiply: given product p and known factor b, it recovers a.
- Inverse is computed iteratively as b⁻¹ = b^14 = b^2 · b^4 · b^8, using one square and one multiply per cycle, then one final multiply by a.
- Sits in RS/BCH decoder datapaths (syndrome normalisation, error-magnitude evaluation) behind a valid/ready handshake.

---
 rtl/gf_div4_if.sv | 22 ++
 rtl/gf_div4.sv | 92 +++++++++
 2 files changed

// File: rtl/gf_div4_if.sv
// Operand/result handshake bundle for the GF(2^4) divider.
// The master side issues operands and consumes quotients; the slave side is the divider.
interface gf_div4_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] q;
  logic       div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, div_by_zero
  );
endinterface

// File: rtl/gf_div4.sv
// Sequential GF(2^4) divider: q = a * b^-1, with b^-1 = b^14 built from three squarings.
// Not pipelined; one operation in flight, registered outputs behind valid/ready.
module gf_div4 #(
  parameter logic [3:0] POLY = 4'b0011
) (
  input  logic      clk,
  input  logic      rst_n,
  gf_div4_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SQ1, SQ2, SQ3, MUL, DONE} state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] a_r;
  logic [3:0] s;
  logic [3:0] acc;
  logic       dz;
  logic [3:0] s_sq;

  // Carry-less product folded back using x^4 = POLY, highest overflow bit first.
  function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (y[i]) p = p ^ ({3'b000, x} << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ ({3'b000, POLY} << (i - 4)) ^ (7'b000_0001 << i);
    return p[3:0];
  endfunction

  assign s_sq = gf_mul(s, s);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid && bus.in_ready) next_state = SQ1;
      SQ1:     next_state = SQ2;
      SQ2:     next_state = SQ3;
      SQ3:     next_state = MUL;
      MUL:     next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake flags are registered from next_state so in_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      state         <= next_state;
      bus.in_ready  <= (next_state == IDLE);
      bus.out_valid <= (next_state == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r             <= '0;
      s               <= '0;
      acc             <= '0;
      dz              <= 1'b0;
      bus.q           <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            a_r <= bus.a;
            s   <= bus.b;
            acc <= 4'b0001;
            dz  <= (bus.b == 4'b0000);
          end
        end
        // Accumulate b^2 * b^4 * b^8 using the freshly squared value.
        SQ1, SQ2, SQ3: begin
          s   <= s_sq;
          acc <= gf_mul(acc, s_sq);
        end
        MUL: begin
          bus.q           <= gf_mul(a_r, acc);
          bus.div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule
